// File: rtl/coordinate_reader_if.sv
// Coordinate stream bundle: one (x, y, index) triple per valid/ready transfer.
interface coordinate_reader_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              coord_valid;
   logic              coord_ready;
   logic [DATA_W-1:0] coord_x;
   logic [DATA_W-1:0] coord_y;
   logic [ADDR_W-1:0] coord_index;

   modport master (
      output coord_valid,
      output coord_x,
      output coord_y,
      output coord_index,
      input  coord_ready
   );

   modport slave (
      input  coord_valid,
      input  coord_x,
      input  coord_y,
      input  coord_index,
      output coord_ready
   );
endinterface

// File: rtl/coordinate_reader.sv
// Read-back engine for XMEM/YMEM: walks node addresses, absorbs RAM latency,
// and streams (x, y, index) triples through a credit-guarded output FIFO.
module coordinate_reader #(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 8,
   parameter int READ_LATENCY = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   num_nodes,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_rd_en,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] x_q,
   input  logic [DATA_W-1:0] y_q,
   coordinate_reader_if.master coord,
   output logic              busy,
   output logic              done
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
   localparam logic [ADDR_W:0] MAXN = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [ADDR_W:0]   r_count;
   logic [ADDR_W-1:0] r_addr;

   logic [READ_LATENCY-1:0] r_pv;
   logic [ADDR_W-1:0]       r_ptag [READ_LATENCY];

   logic [DATA_W-1:0] r_fx [FIFO_DEPTH];
   logic [DATA_W-1:0] r_fy [FIFO_DEPTH];
   logic [ADDR_W-1:0] r_fi [FIFO_DEPTH];
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [CW-1:0]     r_fcnt;

   logic [CW-1:0]   w_inflight;
   logic [ADDR_W:0] w_sat;
   logic            w_flush;
   logic            w_issue;
   logic            w_last;
   logic            w_push;
   logic            w_pop;
   logic            w_accept;
   logic            w_drained;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         w_inflight = w_inflight + CW'(r_pv[i]);
      end
   end

   assign w_sat    = (num_nodes > MAXN) ? MAXN : num_nodes;
   assign w_flush  = abort && (r_state != S_IDLE);
   assign w_accept = (r_state == S_IDLE) && start;
   assign w_last   = ({1'b0, r_addr} == (r_count - 1'b1));
   assign w_push   = r_pv[READ_LATENCY-1];
   assign w_pop    = coord.coord_valid && coord.coord_ready && !w_flush;

   // Credit counts in-flight reads so a stalled consumer can never overflow.
   assign w_issue = (r_state == S_READ) && !abort &&
                    ((r_fcnt + w_inflight) < CW'(FIFO_DEPTH));

   // Let DONE follow the final pop directly instead of a cycle later.
   assign w_drained = (w_inflight == '0) &&
                      ((r_fcnt == '0) || ((r_fcnt == CW'(1)) && w_pop));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (w_flush) begin
         w_next = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_next = (num_nodes == '0) ? S_DONE : S_READ;
               end
            end
            S_READ: begin
               if (w_issue && w_last) begin
                  w_next = S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_drained) begin
                  w_next = S_DONE;
               end
            end
            S_DONE: begin
               w_next = S_IDLE;
            end
            default: begin
               w_next = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
         r_addr  <= '0;
      end else if (w_accept && (num_nodes != '0)) begin
         r_count <= w_sat;
         r_addr  <= '0;
      end else if (w_issue && !w_last) begin
         r_addr <= r_addr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pv <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            r_ptag[i] <= '0;
         end
      end else if (w_flush) begin
         r_pv <= '0;
      end else begin
         r_pv[0]   <= w_issue;
         r_ptag[0] <= r_addr;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_pv[i]   <= r_pv[i-1];
            r_ptag[i] <= r_ptag[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_fcnt <= '0;
      end else if (w_flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_fcnt <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= ptr_inc(r_wptr);
         end
         if (w_pop) begin
            r_rptr <= ptr_inc(r_rptr);
         end
         r_fcnt <= r_fcnt + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fx[i] <= '0;
            r_fy[i] <= '0;
            r_fi[i] <= '0;
         end
      end else if (w_push && !w_flush) begin
         r_fx[r_wptr] <= x_q;
         r_fy[r_wptr] <= y_q;
         r_fi[r_wptr] <= r_ptag[READ_LATENCY-1];
      end
   end

   assign mem_address = r_addr;
   assign mem_rd_en   = w_issue;
   assign mem_wren    = 1'b0;

   assign coord.coord_valid = (r_fcnt != '0);
   assign coord.coord_x     = r_fx[r_rptr];
   assign coord.coord_y     = r_fy[r_rptr];
   assign coord.coord_index = r_fi[r_rptr];

   assign busy = (r_state != S_IDLE);
   assign done = (r_state == S_DONE);

endmodule
